// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF and ID.
// First-word-fall-through circular FIFO carrying the fetch PC, instruction word
// and branch-prediction metadata. An EX redirect flush empties it in one cycle.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PHT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_pred_taken,
  input  logic [PHT_W-1:0]         in_pht_idx,
  input  logic                     in_btb_hit,
  input  logic [31:0]              in_btb_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_pred_taken,
  output logic [PHT_W-1:0]         out_pht_idx,
  output logic                     out_btb_hit,
  output logic [31:0]              out_btb_target,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             pred_taken;
    logic [PHT_W-1:0] pht_idx;
    logic             btb_hit;
    logic [31:0]      btb_target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic            enq, deq;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Status flags derive only from registered pointers: no out_ready->in_ready path.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign enq = in_valid & in_ready & ~flush;
  assign deq = out_valid & out_ready & ~flush;

  // Next-pointer logic; flush wins over any handshake in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is not reset; stale contents are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_idx] <= '{pc:         in_pc,
                         inst:       in_inst,
                         pred_taken: in_pred_taken,
                         pht_idx:    in_pht_idx,
                         btb_hit:    in_btb_hit,
                         btb_target: in_btb_target};
    end
  end

  // Head read at rd_ptr, masked to a NOP bubble when the queue is empty.
  always_comb begin
    head = mem_q[rd_idx];
    if (empty) begin
      head      = '0;
      head.inst = NOP;
    end
  end

  assign out_pc         = head.pc;
  assign out_inst       = head.inst;
  assign out_pred_taken = head.pred_taken;
  assign out_pht_idx    = head.pht_idx;
  assign out_btb_hit    = head.btb_hit;
  assign out_btb_target = head.btb_target;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: offered entries are pushed when the
// reference model accepts them and compared against the head when dequeued.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PHT_W = 5;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             pred_taken;
    logic [PHT_W-1:0] pht_idx;
    logic             btb_hit;
    logic [31:0]      btb_target;
  } entry_t;

  localparam entry_t EMPTY_HEAD = '{pc: 32'h0, inst: 32'h0000_0013, pred_taken: 1'b0,
                                    pht_idx: '0, btb_hit: 1'b0, btb_target: 32'h0};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_pc = '0;
  logic [31:0]      in_inst = '0;
  logic             in_pred_taken = 1'b0;
  logic [PHT_W-1:0] in_pht_idx = '0;
  logic             in_btb_hit = 1'b0;
  logic [31:0]      in_btb_target = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_pred_taken;
  logic [PHT_W-1:0] out_pht_idx;
  logic             out_btb_hit;
  logic [31:0]      out_btb_target;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  entry_t head_act;
  entry_t cur;
  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  if_fetch_queue #(.DEPTH(DEPTH), .PHT_W(PHT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
    .in_pht_idx(in_pht_idx), .in_btb_hit(in_btb_hit), .in_btb_target(in_btb_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pred_taken(out_pred_taken),
    .out_pht_idx(out_pht_idx), .out_btb_hit(out_btb_hit), .out_btb_target(out_btb_target),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  assign head_act = '{pc: out_pc, inst: out_inst, pred_taken: out_pred_taken,
                      pht_idx: out_pht_idx, btb_hit: out_btb_hit, btb_target: out_btb_target};

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    e.pc         = pc;
    e.inst       = 32'hDEAD_0000 | {16'h0, pc[15:0]};
    e.pred_taken = pc[2];
    e.pht_idx    = pc[6:2];
    e.btb_hit    = pc[3] ^ pc[4];
    e.btb_target = pc + 32'h40;
    return e;
  endfunction

  // Set the inputs for the coming cycle (no checking here).
  task automatic offer(input logic v, input logic [31:0] pc, input logic r, input logic f);
    cur           = mk(pc);
    in_valid      = v;
    in_pc         = cur.pc;
    in_inst       = cur.inst;
    in_pred_taken = cur.pred_taken;
    in_pht_idx    = cur.pht_idx;
    in_btb_hit    = cur.btb_hit;
    in_btb_target = cur.btb_target;
    out_ready     = r;
    flush         = f;
  endtask

  // Reference-model update from the pre-edge state, then step one clock.
  task automatic advance();
    logic enq, deq;
    enq = in_valid && (exp_q.size() < DEPTH) && !flush;
    deq = out_ready && (exp_q.size() > 0) && !flush;
    if (flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty, full); end
    checks++; if (head_act !== EMPTY_HEAD) begin errors++; $display("FAIL reset_head got=%h exp=%h", head_act, EMPTY_HEAD); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got=%0b exp=1", i, in_ready); end
      checks++; if (count !== CW'(exp_q.size())) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, exp_q.size()); end
      offer(1'b1, 32'(i * 4), 1'b0, 1'b0);
      advance();
    end
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count_full got=%0d exp=4", count); end
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_flags got full=%0b in_ready=%0b exp 1/0", full, in_ready); end
    checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL fill_head got=%h exp=%h", head_act, exp_q[0]); end
    offer(1'b1, 32'h10, 1'b0, 1'b0);
    advance();
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_drop_count got=%0d exp=4", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL drain_head[%0d] got=%h exp=%h", i, head_act, exp_q[0]); end
      offer(1'b0, 32'h0, 1'b1, 1'b0);
      advance();
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%0b out_valid=%0b exp 1/0", empty, out_valid); end
    checks++; if (head_act !== EMPTY_HEAD) begin errors++; $display("FAIL drain_nop got=%h exp=%h", head_act, EMPTY_HEAD); end
  endtask

  task automatic test_steady();
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      checks++; if (count !== CW'(2)) begin errors++; $display("FAIL steady_count[%0d] got=%0d exp=2", i, count); end
      checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL steady_head[%0d] got=%h exp=%h", i, head_act, exp_q[0]); end
      offer(1'b1, 32'h108 + 32'(i * 4), 1'b1, 1'b0);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL steady_tail[%0d] got=%h exp=%h", i, head_act, exp_q[0]); end
      offer(1'b0, 32'h0, 1'b1, 1'b0);
      advance();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL steady_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_full_deq();
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      advance();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fulldeq_in_ready got=%0b exp=0", in_ready); end
    checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL fulldeq_head got=%h exp=%h", head_act, exp_q[0]); end
    offer(1'b1, 32'h300, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fulldeq_in_ready_rdy got=%0b exp=0", in_ready); end
    advance();
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL fulldeq_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (head_act !== exp_q[0]) begin errors++; $display("FAIL fulldeq_drain[%0d] got=%h exp=%h", i, head_act, exp_q[0]); end
      offer(1'b0, 32'h0, 1'b1, 1'b0);
      advance();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fulldeq_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
      advance();
    end
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    offer(1'b1, 32'h440, 1'b1, 1'b1);
    advance();
    checks++; if (count !== CW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got count=%0d out_valid=%0b exp 0/0", count, out_valid); end
    checks++; if (head_act !== EMPTY_HEAD) begin errors++; $display("FAIL flush_head got=%h exp=%h", head_act, EMPTY_HEAD); end
    offer(1'b1, 32'h500, 1'b0, 1'b0);
    advance();
    checks++; if (count !== CW'(1) || head_act !== exp_q[0]) begin errors++; $display("FAIL flush_resume got count=%0d head=%h exp 1/%h", count, head_act, exp_q[0]); end
    offer(1'b0, 32'h0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0);
      advance();
    end
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL rstmid_pre_count got=%0d exp=2", count); end
    rst = 1'b1;
    #1;
    checks++; if (count !== CW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got count=%0d out_valid=%0b exp 0/0", count, out_valid); end
    checks++; if (head_act !== EMPTY_HEAD) begin errors++; $display("FAIL rstmid_head got=%h exp=%h", head_act, EMPTY_HEAD); end
    exp_q.delete();
    #1;
    rst = 1'b0;
    offer(1'b1, 32'h700, 1'b0, 1'b0);
    advance();
    checks++; if (out_valid !== 1'b1 || head_act !== exp_q[0]) begin errors++; $display("FAIL rstmid_resume got valid=%0b head=%h exp 1/%h", out_valid, head_act, exp_q[0]); end
    offer(1'b0, 32'h0, 1'b1, 1'b0);
    advance();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_full_deq();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the IF stage and the ID stage. It buffers fetched instructions together with their PC and branch-prediction metadata: predicted-taken, PHT index, BTB hit and BTB target. Buffering decouples fetch from decode stalls. It is a small first-word-fall-through circular FIFO. A flush from the EX-stage redirect drops all wrong-path entries in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥ 2.
- PHT_W, 5: width of the PHT index carried with each entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries, driven by the EX redirect.
- in_valid  in  1  fetch side offers an entry this cycle.
- in_ready  out  1  queue accepts an entry; equals ~full.
- in_pc  in  32  fetch PC.
- in_inst  in  32  fetched instruction word.
- in_pred_taken  in  1  gshare prediction.
- in_pht_idx  in  PHT_W  PHT index used for the prediction.
- in_btb_hit  in  1  BTB hit.
- in_btb_target  in  32  BTB target.
- out_valid  out  1  head entry present; equals ~empty.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  32  head PC, or 0 when empty.
- out_inst  out  32  head instruction, or 32'h0000_0013 (NOP) when empty.
- out_pred_taken  out  1  head field, or 0 when empty.
- out_pht_idx  out  PHT_W  head field, or 0 when empty.
- out_btb_hit  out  1  head field, or 0 when empty.
- out_btb_target  out  32  head field, or 0 when empty.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH entries, each holding pc, inst, pred_taken, pht_idx, btb_hit and btb_target (98+PHT_W bits at the defaults).
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits wide. The index is the low bits; the MSB is a wrap bit.
  - empty: pointers are equal.
  - full: indices are equal and wrap bits differ.
  - count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Enqueue fires when in_valid & in_ready & ~flush. The entry is written at wr_ptr and wr_ptr increments.
- Dequeue fires when out_valid & out_ready & ~flush. rd_ptr increments.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Full: in_ready=0 even if a dequeue happens in the same cycle. There is no combinational out_ready→in_ready path.
- Empty: no bypass. An entry written at edge N is visible on out_* after edge N.
- Head fields are combinational reads at rd_ptr, masked to the empty values above when empty.
- Flush has priority over enqueue and dequeue. At the next edge both pointers become 0 and the queue is empty. in_valid/out_ready are ignored during the flush cycle.
- Asynchronous reset: pointers go to 0 immediately. Entry storage is not reset; it is masked by empty.
- Entries leave in strict arrival order; no field is modified in the queue.
- Outputs under reset or flush-then-idle:
  - out_valid=0, in_ready=1, count=0, empty=1, full=0.
  - out_inst=32'h0000_0013, all other out_* fields 0.

## Timing
- Enqueue-to-visible latency: 1 cycle. Dequeue takes effect at the same edge.
- Throughput: 1 enqueue and 1 dequeue per cycle at 0 < count < DEPTH.
- Flush asserted in cycle N: out_valid=0 from edge N+1. An enqueue in cycle N+1 is accepted normally.
- full, empty and count are registered-pointer functions, stable for the whole cycle.
- The queue holds at most DEPTH entries. With DEPTH=4, a 4-cycle decode stall absorbs 4 fetches.
- Reset asserted mid-operation: all entries are discarded asynchronously. Operation resumes on the first edge after deassertion.

## Test plan
- Fill: 4 enqueues with pc=0x0,0x4,0x8,0xC and out_ready=0.
  - Required: count=4, full=1, in_ready=0.
  - A 5th in_valid with pc=0x10 is dropped.
- Drain: with the queue full, out_ready=1 for 4 cycles.
  - Required: out_pc=0x0,0x4,0x8,0xC in order with all metadata intact.
  - Then empty=1 and out_inst=0x00000013.
- Steady state: count=2, then in_valid=out_ready=1 for 10 cycles.
  - Required: count stays 2.
  - Pointers wrap; output order matches input order across the wrap.
- Full plus dequeue: count=4, in_valid=1, out_ready=1.
  - Required: only the dequeue happens; count=3; the offered entry is not written.
- Flush: count=3 with in_valid=1, out_ready=1 and flush=1 in one cycle.
  - Required: next cycle count=0, out_valid=0; the offered entry is absent.
- Reset mid-operation: rst pulsed with count=2.
  - Required: count=0 and out_valid=0 immediately, without waiting for a clock edge.
  - The next enqueue appears at out_* one cycle later.
